// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider and its
// ripple adder/subtractor datapath.
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic s;
        logic co;
    } fa_out_t;

    // One full adder cell; the ripple chain is built by chaining these.
    function automatic fa_out_t full_add(input logic a, input logic b, input logic ci);
        fa_out_t r;
        r.s  = a ^ b ^ ci;
        r.co = (a & b) | (ci & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/addsub_nbit.sv
// Parameterised ripple-carry adder/subtractor: M=0 gives A+B, M=1 gives A-B
// (B inverted, carry-in 1). carryOut=1 on subtract means A >= B.
module addsub_nbit
    import seq_restoring_divider_pkg::*;
#(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         M,
    output logic [N-1:0] sum,
    output logic         carryOut
);

    logic [N:0]   carry;
    logic [N-1:0] b_eff;

    assign b_eff    = B ^ {N{M}};
    assign carry[0] = M;
    assign carryOut = carry[N];

    for (genvar i = 0; i < N; i++) begin : g_cell
        fa_out_t fa;
        assign fa         = full_add(A[i], b_eff[i], carry[i]);
        assign sum[i]     = fa.s;
        assign carry[i+1] = fa.co;
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and divide-by-zero short-cut.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t state, state_next;

    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   r_reg;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             zero_div;
    logic             last_iter;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    assign accept    = start && (state != CALC);
    assign zero_div  = (divisor == '0);
    assign last_iter = (count == LAST_ITER);

    addsub_nbit #(
        .N(WIDTH + 1)
    ) u_trial_sub (
        .A        (shifted),
        .B        ({1'b0, d_reg}),
        .M        (MODE_SUB),
        .sum      (trial),
        .carryOut (trial_ok)
    );

    always_comb begin
        shifted = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        r_next  = trial_ok ? trial : shifted;
        q_next  = {q_reg[WIDTH-2:0], trial_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = zero_div ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // Working registers stay private; results are published only on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                d_reg       <= divisor;
                q_reg       <= dividend;
                r_reg       <= '0;
                count       <= '0;
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            r_reg <= r_next;
            q_reg <= q_next;
            count <= count + CNT_W'(1);
            if (last_iter) begin
                quotient  <= q_next;
                remainder <= r_next[WIDTH-1:0];
            end
        end
    end

    // Partial remainder stays below the divisor, so its top bit never sets.
    assert property (@(posedge clk) disable iff (rst) r_reg[WIDTH] == 1'b0);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed scenarios, random
// operands and an exhaustive sweep against a plain-arithmetic reference.
module tb_seq_restoring_divider;

    localparam int unsigned WIDTH = 4;
    localparam int MAXV = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    int hold_q   = 0;
    int hold_r   = 0;
    int hold_z   = 0;

    seq_restoring_divider #(
        .WIDTH(WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ref_div(input int a, input int b, output int q, output int r);
        if (b == 0) begin
            q = MAXV;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // One full transaction: start for one cycle, then wait for done.
    task automatic run_div(input int a, input int b);
        int q, r, lat, busy_n;
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 4 * WIDTH) begin
            if (busy) busy_n++;
            check("hold_during_calc", quotient, hold_q);
            tick();
            lat++;
        end
        ref_div(a, b, q, r);
        check("latency", lat, (b == 0) ? 0 : WIDTH);
        check("busy_cycles", busy_n, (b == 0) ? 0 : WIDTH);
        check("done", done, 1);
        check("quotient", quotient, q);
        check("remainder", remainder, r);
        check("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
        if (b != 0) begin
            check("invariant_eq", int'(quotient) * b + int'(remainder), a);
            check("invariant_lt", (int'(remainder) < b) ? 1 : 0, 1);
        end
        hold_q = q;
        hold_r = r;
        hold_z = (b == 0) ? 1 : 0;
        tick();
        check("done_one_cycle", done, 0);
        check("held_quotient", quotient, hold_q);
        check("held_remainder", remainder, hold_r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones, last_done, a, b;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst = 1'b0;
        tick();

        run_div(13, 4);
        run_div(15, 1);
        repeat (3) tick();
        check("idle_hold_q", quotient, 15);
        check("idle_hold_r", remainder, 0);
        run_div(5, 7);
        run_div(9, 0);

        // Start pulsed again while busy must be ignored.
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dividend = 4'd2;
        divisor  = 4'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dones++;
                check("ignore_q", quotient, 4);
                check("ignore_r", remainder, 2);
            end
            tick();
        end
        check("ignore_done_count", dones, 1);
        hold_q = 4;
        hold_r = 2;

        // Reset in the second CALC cycle aborts the run.
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            tick();
        end
        check("abort_no_done", dones, 0);
        hold_q = 0;
        hold_r = 0;
        run_div(12, 5);

        // Start held high: back-to-back runs every WIDTH+1 cycles.
        dividend  = 4'd11;
        divisor   = 4'd2;
        start     = 1'b1;
        dones     = 0;
        last_done = -1;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (done) begin
                dones++;
                check("b2b_q", quotient, 5);
                check("b2b_r", remainder, 1);
                if (last_done >= 0) check("b2b_spacing", i - last_done, WIDTH + 1);
                last_done = i;
            end
        end
        check("b2b_done_count", dones, 5);
        start = 1'b0;
        repeat (WIDTH + 3) tick();
        hold_q = 5;
        hold_r = 1;

        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, MAXV));
            b = int'($urandom_range(0, MAXV));
            run_div(a, b);
        end

        for (int x = 0; x <= MAXV; x++) begin
            for (int y = 0; y <= MAXV; y++) begin
                run_div(x, y);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
